// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port plus an outstanding-load scoreboard.
// Optional same-cycle writeback bypass is enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        regWrite,
  output logic [4:0]  write_Register,
  output logic [31:0] write_Data
`ifdef WB_BYPASS_EN
  ,
  output logic        rs1_fwd,
  output logic        rs2_fwd,
  output logic [31:0] fwd_data
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic        alu_req, ld_req;
  logic        alu_win, ld_win;
  logic [3:0]  starve_q, starve_d;
  logic        reg_write_q, reg_write_d;
  logic        wb_is_load_q, wb_is_load_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] busy_q, busy_d;

  // Requests to x0 never compete for the write slot.
  assign alu_req = alu_valid && (alu_rd != 5'd0);
  assign ld_req  = ld_valid && (ld_rd != 5'd0);

  assign alu_win = alu_req && (!ld_req || (starve_q == StarveMax));
  assign ld_win  = ld_req && !alu_win;

  assign alu_ready = !reset && ((alu_rd == 5'd0) || alu_win);
  assign ld_ready  = !reset && ((ld_rd == 5'd0) || ld_win);

  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || alu_ready) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    reg_write_d  = 1'b0;
    wb_is_load_d = 1'b0;
    wa_d         = wa_q;
    wd_d         = wd_q;
    if (alu_win) begin
      reg_write_d = 1'b1;
      wa_d        = alu_rd;
      wd_d        = alu_data;
    end else if (ld_win) begin
      reg_write_d  = 1'b1;
      wb_is_load_d = 1'b1;
      wa_d         = ld_rd;
      wd_d         = ld_data;
    end
  end

  // Set after clear so a re-issue at the commit edge keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q && wb_is_load_q) begin
      busy_d[wa_q] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != 5'd0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q     <= 4'd0;
      reg_write_q  <= 1'b0;
      wb_is_load_q <= 1'b0;
      wa_q         <= 5'd0;
      wd_q         <= 32'd0;
      busy_q       <= 32'd0;
    end else begin
      starve_q     <= starve_d;
      reg_write_q  <= reg_write_d;
      wb_is_load_q <= wb_is_load_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
    end
  end

  assign regWrite       = reg_write_q;
  assign write_Register = wa_q;
  assign write_Data     = wd_q;

`ifdef WB_BYPASS_EN
  assign rs1_fwd  = reg_write_q && (wa_q == rs1) && (rs1 != 5'd0);
  assign rs2_fwd  = reg_write_q && (wa_q == rs2) && (rs2 != 5'd0);
  assign fwd_data = wd_q;
  assign rs1_busy = busy_q[rs1] && !rs1_fwd;
  assign rs2_busy = busy_q[rs2] && !rs2_fwd;
`else
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against an abstract behavioural model,
// plus directed cases with hand-computed expectations.
module tb_regfile_wb_arbiter;

  localparam int Limit = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, ld_issue;
  logic [4:0]  alu_rd, ld_rd, ld_issue_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, rs1_busy, rs2_busy, regWrite;
  logic [4:0]  write_Register;
  logic [31:0] write_Data;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] fwd_data;
`endif

  regfile_wb_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .regWrite(regWrite), .write_Register(write_Register), .write_Data(write_Data)
`ifdef WB_BYPASS_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending-load set, starvation count, and the write-port contents.
  bit [31:0]   m_busy;
  int          m_cnt;
  bit          m_we, m_wl;
  bit [4:0]    m_wa;
  bit [31:0]   m_wd;
  bit          last_ar, last_lr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit mbusy(input bit [4:0] rs);
    bit fwd;
    fwd = 1'b0;
`ifdef WB_BYPASS_EN
    fwd = m_we && (m_wa == rs) && (rs != 0);
`endif
    return (rs != 0) && m_busy[rs] && !fwd;
  endfunction

  // Checks all outputs for the current cycle, then advances the model across the edge.
  task automatic cycle();
    bit a_nz, l_nz, a_g, l_g, e_ar, e_lr;
    bit [31:0] nb;
    a_nz = alu_valid && (alu_rd != 0);
    l_nz = ld_valid && (ld_rd != 0);
    if (a_nz && l_nz) a_g = (m_cnt == Limit);
    else a_g = a_nz;
    l_g = l_nz && !a_g;
    e_ar = !reset && ((alu_rd == 0) || a_g);
    e_lr = !reset && ((ld_rd == 0) || l_g);
    #1;
    chk("alu_ready", alu_ready, e_ar);
    chk("ld_ready", ld_ready, e_lr);
    chk("regWrite", regWrite, m_we);
    chk("write_Register", write_Register, m_wa);
    chk("write_Data", write_Data, m_wd);
    chk("rs1_busy", rs1_busy, mbusy(rs1));
    chk("rs2_busy", rs2_busy, mbusy(rs2));
`ifdef WB_BYPASS_EN
    chk("rs1_fwd", rs1_fwd, m_we && (m_wa == rs1) && (rs1 != 0));
    chk("rs2_fwd", rs2_fwd, m_we && (m_wa == rs2) && (rs2 != 0));
    chk("fwd_data", fwd_data, m_wd);
`endif
    last_ar = alu_ready;
    last_lr = ld_ready;
    @(posedge clk);
    if (reset) begin
      m_busy = '0; m_cnt = 0; m_we = 0; m_wl = 0; m_wa = '0; m_wd = '0;
    end else begin
      nb = m_busy;
      if (m_we && m_wl) nb[m_wa] = 1'b0;
      if (ld_issue && ld_issue_rd != 0) nb[ld_issue_rd] = 1'b1;
      m_busy = nb;
      if (!alu_valid || e_ar) m_cnt = 0;
      else if (m_cnt < Limit) m_cnt = m_cnt + 1;
      if (a_g) begin
        m_we = 1; m_wl = 0; m_wa = alu_rd; m_wd = alu_data;
      end else if (l_g) begin
        m_we = 1; m_wl = 1; m_wa = ld_rd; m_wd = ld_data;
      end else begin
        m_we = 0; m_wl = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; ld_issue = 0;
  endtask

  initial begin
    string seq;
    m_busy = '0; m_cnt = 0; m_we = 0; m_wl = 0; m_wa = '0; m_wd = '0;
    reset = 1; idle();
    alu_rd = 0; ld_rd = 0; ld_issue_rd = 0; rs1 = 0; rs2 = 0; alu_data = 0; ld_data = 0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_readies", {31'd0, last_ar | last_lr}, 32'd0);
    reset = 0;
    alu_rd = 5; alu_data = 32'h1234;
    cycle();
    chk("rst_regWrite", regWrite, 0);

    // Single ALU write
    alu_valid = 1;
    cycle();
    chk("single_ready", last_ar, 1);
    alu_valid = 0;
    chk("single_we", regWrite, 1);
    chk("single_wa", write_Register, 5);
    chk("single_wd", write_Data, 32'h1234);
    cycle();
    chk("single_we_drop", regWrite, 0);

    // Contention: expect L,L,L,A,L,L,L,A
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA; ld_valid = 1; ld_rd = 4; ld_data = 32'hB;
    seq = "";
    for (int i = 0; i < 8; i++) begin
      cycle();
      seq = {seq, last_ar ? "A" : "L"};
    end
    n_tests++;
    if (seq != "LLLALLLA") begin
      n_fail++;
      $display("FAIL starve_seq: got %s, expected LLLALLLA", seq);
    end
    idle();
    cycle();

    // x0 requests
    alu_valid = 1; alu_rd = 0; ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    cycle();
    chk("x0_both_ready", {30'd0, last_ar, last_lr}, 32'd3);
    chk("x0_we", regWrite, 1);
    chk("x0_wa", write_Register, 7);
    ld_valid = 0;
    cycle();
    chk("x0_alone_we", regWrite, 0);
    idle();

    // Scoreboard timing
    rs1 = 9; ld_issue = 1; ld_issue_rd = 9;
    cycle();
    ld_issue = 0;
    chk("sb_busy_after_issue", rs1_busy, 1);
    cycle();
    ld_valid = 1; ld_rd = 9; ld_data = 32'hCAFE; rs2 = 9;
    #1 chk("sb_busy_before_accept", rs1_busy, 1);
    cycle();
    ld_valid = 0;
`ifdef WB_BYPASS_EN
    chk("sb_n1_busy_bypass", rs1_busy, 0);
    chk("bp_rs2_fwd", rs2_fwd, 1);
    chk("bp_fwd_data", fwd_data, 32'hCAFE);
    chk("bp_rs2_busy", rs2_busy, 0);
`else
    chk("sb_n1_busy", rs1_busy, 1);
`endif
    cycle();
    chk("sb_n2_busy", rs1_busy, 0);

    // Re-issue at the commit edge keeps the register busy
    ld_issue = 1; ld_issue_rd = 9;
    cycle();
    ld_issue = 0; ld_valid = 1; ld_rd = 9;
    cycle();
    ld_valid = 0; ld_issue = 1; ld_issue_rd = 9;
    cycle();
    ld_issue = 0;
    chk("sb_set_wins", rs1_busy, 1);

    // Reset one cycle after an accept
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    cycle();
    alu_valid = 1; reset = 1;
    #1 chk("rst_mid_ready", alu_ready, 0);
    cycle();
    idle();
    chk("rst_mid_we", regWrite, 0);
    chk("rst_mid_busy", rs1_busy, 0);
    reset = 0;
    cycle();

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      bit [4:0] r;
      reset     = ($urandom_range(0, 149) == 0);
      alu_valid = ($urandom_range(0, 3) != 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 2) != 0);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      r         = 5'($urandom_range(0, 7));
      ld_issue_rd = r;
      ld_issue  = ($urandom_range(0, 2) == 0) && !m_busy[r];
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
